// File: rtl/tm_cfg_mem_arb.sv
// Shares one single-port TM config RAM between the datapath lookup port and the PIO path.
// Latency: datapath read data 1 cycle after grant; PIO write ack 1 cycle, PIO read ack 3 cycles after issue.
// Backpressure: datapath wins until a pending PIO access has waited STARVE_MAX cycles; ack holds until clk_div=1.
module tm_cfg_mem_arb #(
  parameter int ADDR_NBITS = 8,
  parameter int DATA_NBITS = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_div,
  input  logic                  reg_ms,
  input  logic                  reg_wr,
  input  logic                  reg_rd,
  input  logic [DATA_NBITS-1:0] reg_addr,
  input  logic [DATA_NBITS-1:0] reg_din,
  output logic                  mem_ack,
  output logic [DATA_NBITS-1:0] mem_rdata,
  input  logic                  dp_req,
  input  logic [ADDR_NBITS-1:0] dp_addr,
  output logic                  dp_gnt,
  output logic                  dp_rvalid,
  output logic [DATA_NBITS-1:0] dp_rdata,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [ADDR_NBITS-1:0] ram_addr,
  output logic [DATA_NBITS-1:0] ram_wdata,
  input  logic [DATA_NBITS-1:0] ram_rdata
);

  localparam int CNT_NBITS = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_NBITS-1:0] STARVE_LIM = CNT_NBITS'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, PIO_RD, PIO_CAP, PIO_ACK} state_t;

  state_t                 state_q, state_d;
  logic                   pio_pend_q, pio_pend_d;
  logic                   pio_wr_q, pio_wr_d;
  logic [ADDR_NBITS-1:0]  pio_addr_q, pio_addr_d;
  logic [DATA_NBITS-1:0]  pio_data_q, pio_data_d;
  logic [CNT_NBITS-1:0]   starve_cnt_q, starve_cnt_d;
  logic [DATA_NBITS-1:0]  mem_rdata_q, mem_rdata_d;
  logic                   dp_rvalid_q, dp_rvalid_d;
  logic                   force_pio;
  logic                   pio_take;

  // Only the low address bits select a RAM word; the rest of the PIO address is decoded upstream.
  logic unused_addr_hi;
  assign unused_addr_hi = ^reg_addr[DATA_NBITS-1:ADDR_NBITS];

  assign force_pio = (starve_cnt_q == STARVE_LIM);
  assign pio_take  = reg_ms & (reg_wr | reg_rd) & ~pio_pend_q;

  // PIO capture, arbitration, RAM port drive and FSM next state.
  always_comb begin
    state_d      = state_q;
    pio_pend_d   = pio_pend_q;
    pio_wr_d     = pio_wr_q;
    pio_addr_d   = pio_addr_q;
    pio_data_d   = pio_data_q;
    starve_cnt_d = starve_cnt_q;
    mem_rdata_d  = mem_rdata_q;
    dp_gnt       = 1'b0;
    ram_rd       = 1'b0;
    ram_wr       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;

    // One PIO access at a time; pulses arriving while one is pending are dropped.
    if (pio_take) begin
      pio_pend_d = 1'b1;
      pio_addr_d = reg_addr[ADDR_NBITS-1:0];
      pio_data_d = reg_din;
      pio_wr_d   = reg_wr;
    end

    case (state_q)
      IDLE: begin
        if (dp_req && !force_pio) begin
          dp_gnt   = 1'b1;
          ram_rd   = 1'b1;
          ram_addr = dp_addr;
          // force_pio is false here, so the counter cannot pass its limit.
          if (pio_pend_q) begin
            starve_cnt_d = starve_cnt_q + CNT_NBITS'(1);
          end
        end else if (pio_pend_q) begin
          starve_cnt_d = '0;
          ram_addr     = pio_addr_q;
          if (pio_wr_q) begin
            ram_wr    = 1'b1;
            ram_wdata = pio_data_q;
            state_d   = PIO_ACK;
          end else begin
            ram_rd  = 1'b1;
            state_d = PIO_RD;
          end
        end
      end
      PIO_RD: begin
        state_d = PIO_CAP;
      end
      PIO_CAP: begin
        // RAM output still holds the PIO word: nothing was read in PIO_RD.
        mem_rdata_d = ram_rdata;
        state_d     = PIO_ACK;
      end
      PIO_ACK: begin
        // RAM is idle while the ack waits for tm_pio, so the datapath may use it.
        if (dp_req) begin
          dp_gnt   = 1'b1;
          ram_rd   = 1'b1;
          ram_addr = dp_addr;
        end
        if (clk_div) begin
          state_d    = IDLE;
          pio_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dp_rvalid_d = dp_gnt;

  // State and capture registers; reset drops any pending or in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pio_pend_q   <= 1'b0;
      pio_wr_q     <= 1'b0;
      pio_addr_q   <= '0;
      pio_data_q   <= '0;
      starve_cnt_q <= '0;
      mem_rdata_q  <= '0;
      dp_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pio_pend_q   <= pio_pend_d;
      pio_wr_q     <= pio_wr_d;
      pio_addr_q   <= pio_addr_d;
      pio_data_q   <= pio_data_d;
      starve_cnt_q <= starve_cnt_d;
      mem_rdata_q  <= mem_rdata_d;
      dp_rvalid_q  <= dp_rvalid_d;
    end
  end

  assign mem_ack   = (state_q == PIO_ACK);
  assign mem_rdata = mem_rdata_q;
  assign dp_rvalid = dp_rvalid_q;
  // RAM output is already registered; gate it so dp_rdata is quiet outside valid cycles.
  assign dp_rdata  = dp_rvalid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_tm_cfg_mem_arb.sv
// Directed bench for tm_cfg_mem_arb with a behavioural single-port RAM.
// Unwritten RAM words read as 32'hA500_0000 | addr.
// Inputs change 1ns after posedge; outputs are sampled 2ns after posedge.
module tb_tm_cfg_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_div;
  logic        reg_ms, reg_wr, reg_rd;
  logic [31:0] reg_addr, reg_din;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        dp_req;
  logic [7:0]  dp_addr;
  logic        dp_gnt, dp_rvalid;
  logic [31:0] dp_rdata;
  logic        ram_rd, ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic [31:0] tb_mem [256];
  logic        tb_written [256];

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  logic div4 = 1'b0;

  tm_cfg_mem_arb #(.ADDR_NBITS(8), .DATA_NBITS(32), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
    .reg_ms(reg_ms), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_din(reg_din),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_gnt(dp_gnt),
    .dp_rvalid(dp_rvalid), .dp_rdata(dp_rdata),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read output that holds between reads.
  always @(posedge clk) begin
    if (ram_wr) begin
      tb_mem[ram_addr]     <= ram_wdata;
      tb_written[ram_addr] <= 1'b1;
    end
    if (ram_rd) begin
      ram_rdata <= (tb_written[ram_addr] === 1'b1) ? tb_mem[ram_addr]
                                                 : (32'hA500_0000 | {24'h0, ram_addr});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
    if (div4) clk_div = (cyc % 4 == 3);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; clk_div = 1'b1; reg_ms = 0; reg_wr = 0; reg_rd = 0;
    reg_addr = '0; reg_din = '0; dp_req = 0; dp_addr = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_ack",   32'(mem_ack),   0);
    chk("rst_mem_rdata", mem_rdata,      0);
    chk("rst_dp_gnt",    32'(dp_gnt),    0);
    chk("rst_dp_rvalid", 32'(dp_rvalid), 0);
    chk("rst_dp_rdata",  dp_rdata,       0);
    chk("rst_ram_rd",    32'(ram_rd),    0);
    chk("rst_ram_wr",    32'(ram_wr),    0);
    chk("rst_ram_addr",  32'(ram_addr),  0);
    chk("rst_ram_wdata", ram_wdata,      0);
    next(); next(); rst_n = 1'b1;

    // PIO write 0x12 <= DEADBEEF; upper address bits must be ignored
    next(); clk_div = 0; reg_ms = 1; reg_wr = 1; reg_addr = 32'hFFFF_FF12; reg_din = 32'hDEAD_BEEF; settle();
    chk("wr_not_yet", 32'(ram_wr), 0);
    next(); reg_ms = 0; reg_wr = 0; settle();
    chk("wr_issue",       32'(ram_wr),   1);
    chk("wr_issue_rd",    32'(ram_rd),   0);
    chk("wr_issue_addr",  32'(ram_addr), 32'h12);
    chk("wr_issue_wdata", ram_wdata,     32'hDEAD_BEEF);
    chk("wr_issue_ack",   32'(mem_ack),  0);
    next(); settle();
    chk("wr_ack_rise",  32'(mem_ack),  1);
    chk("wr_ack_nowr",  32'(ram_wr),   0);
    chk("wr_idle_addr", 32'(ram_addr), 0);
    next(); settle();
    chk("wr_ack_hold", 32'(mem_ack), 1);
    next(); clk_div = 1; settle();
    chk("wr_ack_div", 32'(mem_ack), 1);
    next(); clk_div = 0; settle();
    chk("wr_ack_fall",     32'(mem_ack), 0);
    chk("wr_rdata_unchg",  mem_rdata,    0);

    // PIO read 0x12: ack 3 cycles after issue, held until clk_div
    next(); reg_ms = 1; reg_rd = 1; reg_addr = 32'h12; settle();
    next(); reg_ms = 0; reg_rd = 0; settle();
    chk("rd_issue",      32'(ram_rd),   1);
    chk("rd_issue_addr", 32'(ram_addr), 32'h12);
    chk("rd_issue_wr",   32'(ram_wr),   0);
    next(); settle();
    chk("rd_t1_ack", 32'(mem_ack), 0);
    next(); settle();
    chk("rd_t2_ack", 32'(mem_ack), 0);
    next(); settle();
    chk("rd_t3_ack",   32'(mem_ack), 1);
    chk("rd_t3_rdata", mem_rdata,    32'hDEAD_BEEF);
    next(); settle();
    chk("rd_ack_hold",   32'(mem_ack), 1);
    chk("rd_rdata_hold", mem_rdata,    32'hDEAD_BEEF);
    next(); clk_div = 1; settle();
    chk("rd_ack_div", 32'(mem_ack), 1);
    next(); clk_div = 0; settle();
    chk("rd_ack_fall",   32'(mem_ack), 0);
    chk("rd_rdata_keep", mem_rdata,    32'hDEAD_BEEF);

    // clk_div 1-in-4: ack rises on a clk_div=0 cycle and waits for the strobe
    next(); cyc = 0; div4 = 1; clk_div = 0; reg_ms = 1; reg_rd = 1; reg_addr = 32'h40; settle();
    next(); reg_ms = 0; reg_rd = 0; settle();
    chk("div4_issue",      32'(ram_rd),   1);
    chk("div4_issue_addr", 32'(ram_addr), 32'h40);
    next(); next(); settle();
    chk("div4_cap_noack", 32'(mem_ack), 0);
    next(); settle();
    chk("div4_ack_rise", 32'(mem_ack), 1);
    chk("div4_ack_data", mem_rdata,    32'hA500_0040);
    next(); next(); settle();
    chk("div4_ack_hold", 32'(mem_ack), 1);
    next(); settle();
    chk("div4_ack_strobe", 32'(mem_ack), 1);
    next(); settle();
    chk("div4_ack_fall", 32'(mem_ack), 0);
    div4 = 0; clk_div = 0;

    // Starvation: continuous datapath traffic, PIO read forced through after 8 grants
    next(); dp_req = 1; dp_addr = 8'h80; reg_ms = 1; reg_rd = 1; reg_addr = 32'h05; settle();
    chk("stv_gnt0",  32'(dp_gnt),   1);
    chk("stv_addr0", 32'(ram_addr), 32'h80);
    for (int k = 1; k <= 8; k++) begin
      next(); reg_ms = 0; reg_rd = 0; dp_addr = 8'(8'h80 + k); settle();
      chk("stv_gnt",    32'(dp_gnt),    1);
      chk("stv_addr",   32'(ram_addr),  32'h80 + 32'(k));
      chk("stv_rvalid", 32'(dp_rvalid), 1);
      chk("stv_rdata",  dp_rdata,       32'hA500_0080 + 32'(k) - 32'd1);
    end
    next(); dp_addr = 8'h89; settle();
    chk("stv_force_gnt",    32'(dp_gnt),    0);
    chk("stv_force_rd",     32'(ram_rd),    1);
    chk("stv_force_addr",   32'(ram_addr),  32'h05);
    chk("stv_force_rvalid", 32'(dp_rvalid), 1);
    chk("stv_force_rdata",  dp_rdata,       32'hA500_0088);
    next(); dp_addr = 8'h8A; settle();
    chk("stv_piord_gnt",    32'(dp_gnt),    0);
    chk("stv_piord_rd",     32'(ram_rd),    0);
    chk("stv_piord_rvalid", 32'(dp_rvalid), 0);
    next(); dp_addr = 8'h8B; settle();
    chk("stv_cap_gnt", 32'(dp_gnt),  0);
    chk("stv_cap_ack", 32'(mem_ack), 0);
    next(); dp_addr = 8'h8C; settle();
    chk("stv_ack_gnt",   32'(dp_gnt),   1);
    chk("stv_ack_addr",  32'(ram_addr), 32'h8C);
    chk("stv_ack",       32'(mem_ack),  1);
    chk("stv_ack_rdata", mem_rdata,     32'hA500_0005);
    next(); dp_req = 0; clk_div = 1; settle();
    chk("stv_ack_div",    32'(mem_ack),   1);
    chk("stv_dp_rvalid",  32'(dp_rvalid), 1);
    chk("stv_dp_rdata",   dp_rdata,       32'hA500_008C);
    chk("stv_dp_nogt",    32'(dp_gnt),    0);
    next(); clk_div = 0; settle();
    chk("stv_ack_fall",    32'(mem_ack),   0);
    chk("stv_rvalid_fall", 32'(dp_rvalid), 0);

    // wr+rd together: write wins; a second pulse while pending is ignored
    next(); reg_ms = 1; reg_wr = 1; reg_rd = 1; reg_addr = 32'h33; reg_din = 32'h1234_5678; settle();
    next(); reg_wr = 0; reg_rd = 1; reg_addr = 32'h44; settle();
    chk("both_wr",    32'(ram_wr),   1);
    chk("both_nord",  32'(ram_rd),   0);
    chk("both_addr",  32'(ram_addr), 32'h33);
    chk("both_wdata", ram_wdata,     32'h1234_5678);
    next(); reg_ms = 0; reg_rd = 0; clk_div = 1; settle();
    chk("both_ack", 32'(mem_ack), 1);
    next(); clk_div = 0; settle();
    chk("both_ack_fall", 32'(mem_ack), 0);
    chk("both_rdata",    mem_rdata,    32'hA500_0005);
    for (int i = 0; i < 3; i++) begin
      next(); settle();
      chk("both_quiet_ack", 32'(mem_ack), 0);
      chk("both_quiet_rd",  32'(ram_rd),  0);
      chk("both_quiet_wr",  32'(ram_wr),  0);
    end
    next(); reg_ms = 1; reg_rd = 1; reg_addr = 32'h33; settle();
    next(); reg_ms = 0; reg_rd = 0; settle();
    chk("both_rb_addr", 32'(ram_addr), 32'h33);
    next(); next(); next(); clk_div = 1; settle();
    chk("both_rb_ack",  32'(mem_ack), 1);
    chk("both_rb_data", mem_rdata,    32'h1234_5678);
    next(); clk_div = 0; settle();
    chk("both_rb_fall", 32'(mem_ack), 0);

    // Reset with a datapath read in flight
    next(); dp_req = 1; dp_addr = 8'h91; settle();
    chk("rstdp_gnt", 32'(dp_gnt), 1);
    next(); dp_req = 0; settle();
    chk("rstdp_pre_rvalid", 32'(dp_rvalid), 1);
    rst_n = 0; settle();
    chk("rstdp_rvalid", 32'(dp_rvalid), 0);
    chk("rstdp_rdata",  dp_rdata,       0);
    next(); rst_n = 1; settle();
    chk("rstdp_after", 32'(dp_rvalid), 0);

    // Reset while in PIO_RD
    next(); reg_ms = 1; reg_rd = 1; reg_addr = 32'h12; settle();
    next(); reg_ms = 0; reg_rd = 0; settle();
    chk("rstrd_issue", 32'(ram_rd), 1);
    next(); rst_n = 0; settle();
    chk("rstrd_ack",     32'(mem_ack),   0);
    chk("rstrd_rdata",   mem_rdata,      0);
    chk("rstrd_ram_rd",  32'(ram_rd),    0);
    chk("rstrd_ram_wr",  32'(ram_wr),    0);
    chk("rstrd_addr",    32'(ram_addr),  0);
    chk("rstrd_gnt",     32'(dp_gnt),    0);
    chk("rstrd_rvalid",  32'(dp_rvalid), 0);
    next(); rst_n = 1; clk_div = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rstrd_no_ack",    32'(mem_ack),   0);
      chk("rstrd_no_rvalid", 32'(dp_rvalid), 0);
      chk("rstrd_no_rd",     32'(ram_rd),    0);
      next();
    end

    // Recovery: write then read back 0x55
    reg_ms = 1; reg_wr = 1; reg_addr = 32'h55; reg_din = 32'hCAFE_F00D; settle();
    next(); reg_ms = 0; reg_wr = 0; settle();
    chk("rec_wr",      32'(ram_wr),   1);
    chk("rec_wr_addr", 32'(ram_addr), 32'h55);
    next(); settle();
    chk("rec_wr_ack", 32'(mem_ack), 1);
    next(); settle();
    chk("rec_wr_fall", 32'(mem_ack), 0);
    next(); reg_ms = 1; reg_rd = 1; reg_addr = 32'h55; settle();
    next(); reg_ms = 0; reg_rd = 0; settle();
    chk("rec_rd", 32'(ram_rd), 1);
    next(); next(); next(); settle();
    chk("rec_rd_ack",  32'(mem_ack), 1);
    chk("rec_rd_data", mem_rdata,    32'hCAFE_F00D);
    next(); settle();
    chk("rec_rd_fall", 32'(mem_ack), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
